// File: rtl/conv_output_stage.sv
// Convolution output stage: requantize accumulator results, tag them with output-map row/col,
// buffer them in a first-word fall-through FIFO and emit them on a valid/ready stream.
// Optional macro CONV_OUT_RELU_EN fuses a ReLU after saturation (negative samples become 0).
module conv_output_stage #(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 5,
  parameter int IMAGE_SIZE  = 28,
  parameter int ACC_WIDTH   = 32,
  parameter int FRAC_BITS   = 8,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              enable,
  input  logic [ACC_WIDTH-1:0]                              in_acc,
  output logic                                              out_valid,
  input  logic                                              out_ready,
  output logic [DATA_WIDTH-1:0]                             out_data,
  output logic [$clog2(IMAGE_SIZE-KERNEL_SIZE+1)-1:0]       out_row,
  output logic [$clog2(IMAGE_SIZE-KERNEL_SIZE+1)-1:0]       out_col,
  output logic                                              out_last,
  output logic                                              frame_done,
  output logic                                              overflow
);

  localparam int OUT_SIZE = IMAGE_SIZE - KERNEL_SIZE + 1;
  localparam int POS_W    = $clog2(OUT_SIZE);
  localparam int PTR_W    = $clog2(FIFO_DEPTH);

  localparam logic [POS_W-1:0] POS_MAX = POS_W'(OUT_SIZE - 1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    ACC_WIDTH'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    ACC_WIDTH'(-(64'sd1 <<< (DATA_WIDTH - 1)));

  typedef struct packed {
    logic                  last;
    logic [POS_W-1:0]      row;
    logic [POS_W-1:0]      col;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  // ------------------------------------------------------------------
  // Requantization: arithmetic shift, saturate, optional ReLU
  // ------------------------------------------------------------------
  logic signed [ACC_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0]       sat_data;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    shifted  = $signed(in_acc) >>> FRAC_BITS;
    sat_data = shifted[DATA_WIDTH-1:0];
    if (shifted > SAT_MAX) begin
      sat_data = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      sat_data = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end
`ifdef CONV_OUT_RELU_EN
    if (sat_data[DATA_WIDTH-1]) begin
      sat_data = '0;
    end
`else
`endif
  end

  // ------------------------------------------------------------------
  // Position counters and stage-1 register
  // ------------------------------------------------------------------
  logic [POS_W-1:0] row_cnt;
  logic [POS_W-1:0] col_cnt;
  logic             s1_valid;
  entry_t           s1_entry;

  // NOTE: clocked state is updated with non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_cnt  <= '0;
      col_cnt  <= '0;
      s1_valid <= 1'b0;
      s1_entry <= '0;
    end else begin
      s1_valid <= enable;
      if (enable) begin
        s1_entry.data <= sat_data;
        s1_entry.row  <= row_cnt;
        s1_entry.col  <= col_cnt;
        s1_entry.last <= (row_cnt == POS_MAX) && (col_cnt == POS_MAX);
        // Counters advance even when the sample is later dropped, keeping tags aligned.
        if (col_cnt == POS_MAX) begin
          col_cnt <= '0;
          row_cnt <= (row_cnt == POS_MAX) ? '0 : row_cnt + POS_W'(1);
        end else begin
          col_cnt <= col_cnt + POS_W'(1);
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Output FIFO (first-word fall-through)
  // ------------------------------------------------------------------
  entry_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;
  entry_t           head;

  assign full  = (count == CNT_FULL);
  assign pop   = out_valid && out_ready;
  assign push  = s1_valid && (!full || pop);
  assign drop  = s1_valid && full && !pop;
  assign head  = mem[rd_ptr];

  // NOTE: the storage array has no reset; emptiness is tracked by count, and the
  // head is masked at the outputs while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s1_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
      frame_done <= pop && head.last;
    end
  end

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? head.data : '0;
  assign out_row   = out_valid ? head.row  : '0;
  assign out_col   = out_valid ? head.col  : '0;
  assign out_last  = out_valid && head.last;

endmodule
